// File: rtl/song_pkg.sv
// Shared definitions for the song writer: FSM state encoding, song word
// layout, index/gap limits, register bundles and word-encoding helpers.
//
// Song word layout (16 bits):
//   wait word : [15]=1, [14:9]=beats,  [8:0]=0
//   note word : [15]=0, [14:9]=note,   [8:3]=duration, [2:0]=0
//   end word  : 16'h0000
package song_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECORD  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_NOTE = 3'd3,
    S_WR_END  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int WAIT_FLAG_BIT = 15;
  localparam int FIELD_A_MSB   = 14;  // beats (wait) or note (note word)
  localparam int FIELD_A_LSB   = 9;
  localparam int DUR_MSB       = 8;
  localparam int DUR_LSB       = 3;

  localparam logic [15:0] END_WORD  = 16'h0000;
  localparam logic [15:0] WAIT_FLAG = 16'h8000;
  localparam logic [6:0]  MAX_INDEX = 7'd126;
  localparam logic [5:0]  GAP_MAX   = 6'd63;

  // Control state carried between cycles.
  typedef struct packed {
    state_t     state;
    logic [1:0] slot;
    logic [6:0] idx;
    logic [5:0] gap;   // beats counted since the last accepted note
    logic [5:0] wgap;  // gap captured for the pending wait word
    logic [5:0] note;
    logic [5:0] dur;
    logic       pend;  // a note word follows the wait word
    logic       ovf;
  } ctl_t;

  // Registered output bundle.
  typedef struct packed {
    logic        note_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic        recording;
    logic        rec_done;
  } out_t;

  function automatic logic [15:0] wait_word(input logic [5:0] beats);
    logic [15:0] w;
    w = WAIT_FLAG;
    w[FIELD_A_MSB:FIELD_A_LSB] = beats;
    return w;
  endfunction

  function automatic logic [15:0] note_word(input logic [5:0] note, input logic [5:0] dur);
    logic [15:0] w;
    w = 16'h0000;
    w[FIELD_A_MSB:FIELD_A_LSB] = note;
    w[DUR_MSB:DUR_LSB]         = dur;
    return w;
  endfunction

  // Add one beat to a gap, holding at GAP_MAX.
  function automatic logic [5:0] gap_add(input logic [5:0] gap, input logic beat);
    logic [5:0] g;
    if (beat && (gap != GAP_MAX)) begin
      g = gap + 6'd1;
    end else begin
      g = gap;
    end
    return g;
  endfunction

endpackage

// File: rtl/song_writer_if.sv
// Bus between the note source / song RAM side and the song writer.
//   slave  : the song_writer itself (consumes controls and notes, drives writes)
//   master : the environment (drives controls and notes, observes writes)
interface song_writer_if;
  logic        record;
  logic [1:0]  slot;
  logic        beat;
  logic        note_valid;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        note_ready;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        recording;
  logic        rec_done;
  logic        overflow;

  modport slave (
    input  record, slot, beat, note_valid, note, duration,
    output note_ready, wr_en, wr_addr, wr_data, recording, rec_done, overflow
  );

  modport master (
    output record, slot, beat, note_valid, note, duration,
    input  note_ready, wr_en, wr_addr, wr_data, recording, rec_done, overflow
  );
endinterface

// File: rtl/song_writer_dffar.sv
// dffar: parameterised-width register with asynchronous active-high reset to 0.
//   clk   : clock
//   reset : asynchronous clear
//   d / q : data in / registered data out (W bits)
module dffar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/song_writer.sv
// song_writer: captures timed note events into a song RAM slot as a stream of
// wait/note words terminated by an end word.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : song_writer_if.slave -- record/slot/beat controls, note
//                handshake (note_valid/note/duration/note_ready), RAM write
//                port (wr_en/wr_addr/wr_data) and status (recording,
//                rec_done, overflow)
// All outputs are registered: the combinational block computes the next
// control state and then the output values that state will present.
module song_writer
  import song_pkg::*;
(
  input logic        clk,
  input logic        reset,
  song_writer_if.slave bus
);

  ctl_t ctl_r, ctl_n;
  out_t out_r, out_n;

  dffar #(.W($bits(ctl_t))) u_ctl (.clk(clk), .reset(reset), .d(ctl_n), .q(ctl_r));
  dffar #(.W($bits(out_t))) u_out (.clk(clk), .reset(reset), .d(out_n), .q(out_r));

  // Next-state logic for the recording FSM and its data registers.
  always_comb begin
    ctl_n = ctl_r;
    case (ctl_r.state)
      S_IDLE: begin
        if (bus.record) begin
          ctl_n.state = S_RECORD;
          ctl_n.slot  = bus.slot;
          ctl_n.idx   = 7'd0;
          ctl_n.gap   = 6'd0;
          ctl_n.ovf   = 1'b0;
        end else begin
          ctl_n.state = S_IDLE;
        end
      end
      S_RECORD: begin
        if (!bus.record) begin
          // Stop: the trailing gap is not written.
          ctl_n.state = S_WR_END;
          ctl_n.gap   = 6'd0;
        end else if (bus.note_valid && ((bus.note != 6'd0) || (bus.duration != 6'd0))) begin
          // A coincident beat belongs to this note's gap.
          ctl_n.note  = bus.note;
          ctl_n.dur   = bus.duration;
          ctl_n.wgap  = gap_add(ctl_r.gap, bus.beat);
          ctl_n.gap   = 6'd0;
          ctl_n.pend  = 1'b1;
          ctl_n.state = (ctl_n.wgap != 6'd0) ? S_WR_WAIT : S_WR_NOTE;
        end else if (bus.beat && (ctl_r.gap == GAP_MAX)) begin
          // Gap counter full: flush a maximal wait word, carry this beat.
          ctl_n.wgap  = GAP_MAX;
          ctl_n.gap   = 6'd1;
          ctl_n.pend  = 1'b0;
          ctl_n.state = S_WR_WAIT;
        end else begin
          // Idle cycle or an all-zero event (accepted and dropped).
          ctl_n.gap = gap_add(ctl_r.gap, bus.beat);
        end
      end
      S_WR_WAIT: begin
        ctl_n.gap = gap_add(ctl_r.gap, bus.beat);
        ctl_n.idx = ctl_r.idx + 7'd1;
        if (ctl_r.idx == MAX_INDEX) begin
          // Last non-end slot used: the pending note is dropped.
          ctl_n.state = S_WR_END;
          ctl_n.ovf   = 1'b1;
          ctl_n.pend  = 1'b0;
        end else if (ctl_r.pend) begin
          ctl_n.state = S_WR_NOTE;
        end else begin
          ctl_n.state = S_RECORD;
        end
      end
      S_WR_NOTE: begin
        ctl_n.gap  = gap_add(ctl_r.gap, bus.beat);
        ctl_n.idx  = ctl_r.idx + 7'd1;
        ctl_n.pend = 1'b0;
        if (ctl_r.idx == MAX_INDEX) begin
          ctl_n.state = S_WR_END;
          ctl_n.ovf   = 1'b1;
        end else begin
          ctl_n.state = S_RECORD;
        end
      end
      S_WR_END: begin
        ctl_n.idx   = ctl_r.idx + 7'd1;
        ctl_n.gap   = 6'd0;
        ctl_n.state = S_DONE;
      end
      S_DONE: begin
        if (!bus.record) begin
          ctl_n.state = S_IDLE;
        end else begin
          ctl_n.state = S_DONE;
        end
      end
      default: begin
        ctl_n = '0;
      end
    endcase
  end

  // Output values presented while in the next state.
  always_comb begin
    out_n            = '0;
    out_n.note_ready = (ctl_n.state == S_RECORD);
    out_n.recording  = (ctl_n.state != S_IDLE) && (ctl_n.state != S_DONE);
    out_n.rec_done   = (ctl_n.state == S_DONE) && (ctl_r.state == S_WR_END);
    case (ctl_n.state)
      S_WR_WAIT: begin
        out_n.wr_en   = 1'b1;
        out_n.wr_addr = {ctl_n.slot, ctl_n.idx};
        out_n.wr_data = wait_word(ctl_n.wgap);
      end
      S_WR_NOTE: begin
        out_n.wr_en   = 1'b1;
        out_n.wr_addr = {ctl_n.slot, ctl_n.idx};
        out_n.wr_data = note_word(ctl_n.note, ctl_n.dur);
      end
      S_WR_END: begin
        out_n.wr_en   = 1'b1;
        out_n.wr_addr = {ctl_n.slot, ctl_n.idx};
        out_n.wr_data = END_WORD;
      end
      default: begin
        out_n.wr_en = 1'b0;
      end
    endcase
  end

  assign bus.note_ready = out_r.note_ready;
  assign bus.wr_en      = out_r.wr_en;
  assign bus.wr_addr    = out_r.wr_addr;
  assign bus.wr_data    = out_r.wr_data;
  assign bus.recording  = out_r.recording;
  assign bus.rec_done   = out_r.rec_done;
  assign bus.overflow   = ctl_r.ovf;

endmodule

// File: tb/tb_song_writer.sv
// Directed testbench for song_writer: linear sequence of stimulus steps with
// hand-computed expected words, addresses and status values.
module tb_song_writer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   wr_cnt;
  int   cnt_snap;
  logic [5:0]  nv;
  logic [15:0] ram [512];

  song_writer_if bus ();

  song_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song RAM model and write counter driven by the write port.
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      ram[bus.wr_addr] <= bus.wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wr_cnt = 0;
    reset = 1'b1;
    bus.record = 1'b0;
    bus.slot = 2'd0;
    bus.beat = 1'b0;
    bus.note_valid = 1'b0;
    bus.note = 6'd0;
    bus.duration = 6'd0;
    tick();
    tick();
    chk("rst_wr_en",     32'(bus.wr_en),      32'd0);
    chk("rst_wr_data",   32'(bus.wr_data),    32'd0);
    chk("rst_ready",     32'(bus.note_ready), 32'd0);
    chk("rst_recording", 32'(bus.recording),  32'd0);
    chk("rst_rec_done",  32'(bus.rec_done),   32'd0);
    chk("rst_overflow",  32'(bus.overflow),   32'd0);

    // A: slot 2, one note at gap 0, then stop.
    bus.slot = 2'd2;
    bus.record = 1'b1;
    reset = 1'b0;
    tick();
    chk("A_ready",     32'(bus.note_ready), 32'd1);
    chk("A_recording", 32'(bus.recording),  32'd1);
    bus.note_valid = 1'b1; bus.note = 6'd12; bus.duration = 6'd4;
    tick();
    chk("A_note_we",    32'(bus.wr_en),      32'd1);
    chk("A_note_addr",  32'(bus.wr_addr),    32'h100);
    chk("A_note_data",  32'(bus.wr_data),    32'h1820);
    chk("A_note_ready", 32'(bus.note_ready), 32'd0);
    bus.note_valid = 1'b0;
    bus.record = 1'b0;
    tick();
    chk("A_rec_we",   32'(bus.wr_en),   32'd0);
    chk("A_rec_data", 32'(bus.wr_data), 32'd0);
    tick();
    chk("A_end_we",   32'(bus.wr_en),   32'd1);
    chk("A_end_addr", 32'(bus.wr_addr), 32'h101);
    chk("A_end_data", 32'(bus.wr_data), 32'h0000);
    tick();
    chk("A_done_pulse", 32'(bus.rec_done),  32'd1);
    chk("A_done_rec",   32'(bus.recording), 32'd0);
    chk("A_done_we",    32'(bus.wr_en),     32'd0);
    tick();
    chk("A_idle_pulse", 32'(bus.rec_done), 32'd0);
    chk("A_ram0", 32'(ram[9'h100]), 32'h1820);
    chk("A_ram1", 32'(ram[9'h101]), 32'h0000);

    // B: slot 1, 3 beats then note 5/dur 2.
    bus.slot = 2'd1;
    bus.record = 1'b1;
    tick();
    bus.beat = 1'b1;
    tick(); tick(); tick();
    bus.beat = 1'b0;
    bus.note_valid = 1'b1; bus.note = 6'd5; bus.duration = 6'd2;
    tick();
    chk("B_wait_addr",  32'(bus.wr_addr),    32'h080);
    chk("B_wait_data",  32'(bus.wr_data),    32'h8600);
    chk("B_wait_ready", 32'(bus.note_ready), 32'd0);
    bus.note_valid = 1'b0;
    tick();
    chk("B_note_addr",  32'(bus.wr_addr),    32'h081);
    chk("B_note_data",  32'(bus.wr_data),    32'h0A10);
    chk("B_note_ready", 32'(bus.note_ready), 32'd0);
    tick();
    chk("B_back_ready", 32'(bus.note_ready), 32'd1);
    chk("B_back_we",    32'(bus.wr_en),      32'd0);

    // C: 2 beats, then a beat coincident with acceptance -> wait 3.
    bus.beat = 1'b1;
    tick(); tick();
    bus.note_valid = 1'b1; bus.note = 6'd7; bus.duration = 6'd1;
    tick();
    chk("C_wait_addr", 32'(bus.wr_addr), 32'h082);
    chk("C_wait_data", 32'(bus.wr_data), 32'h8600);
    bus.beat = 1'b0;
    bus.note_valid = 1'b0;
    tick();
    chk("C_note_addr", 32'(bus.wr_addr), 32'h083);
    chk("C_note_data", 32'(bus.wr_data), 32'h0E08);
    tick();

    // D: all-zero event is dropped and keeps the running gap.
    bus.beat = 1'b1;
    tick();
    bus.beat = 1'b0;
    bus.note_valid = 1'b1; bus.note = 6'd0; bus.duration = 6'd0;
    tick();
    chk("D_zero_we",    32'(bus.wr_en),      32'd0);
    chk("D_zero_ready", 32'(bus.note_ready), 32'd1);
    bus.note = 6'd9; bus.duration = 6'd3;
    tick();
    chk("D_wait_addr", 32'(bus.wr_addr), 32'h084);
    chk("D_wait_data", 32'(bus.wr_data), 32'h8200);
    bus.note_valid = 1'b0;
    tick();
    chk("D_note_data", 32'(bus.wr_data), 32'h1218);
    tick();

    // E: 64 beats with no notes -> wait 63 after beat 64, gap restarts at 1.
    cnt_snap = wr_cnt;
    bus.beat = 1'b1;
    repeat (63) tick();
    chk("E_no_writes", 32'(wr_cnt - cnt_snap), 32'd0);
    chk("E_pre_we",    32'(bus.wr_en),         32'd0);
    tick();
    chk("E_sat_we",   32'(bus.wr_en),   32'd1);
    chk("E_sat_addr", 32'(bus.wr_addr), 32'h086);
    chk("E_sat_data", 32'(bus.wr_data), 32'hFE00);
    bus.beat = 1'b0;
    tick();
    chk("E_back_we",    32'(bus.wr_en),      32'd0);
    chk("E_back_ready", 32'(bus.note_ready), 32'd1);
    bus.note_valid = 1'b1; bus.note = 6'd3; bus.duration = 6'd3;
    tick();
    chk("E_gap1_addr", 32'(bus.wr_addr), 32'h087);
    chk("E_gap1_data", 32'(bus.wr_data), 32'h8200);
    bus.note_valid = 1'b0;
    tick();
    chk("E_note_data", 32'(bus.wr_data), 32'h0618);
    tick();

    // F: reset asserted during WR_WAIT clears outputs immediately.
    bus.beat = 1'b1;
    tick();
    bus.beat = 1'b0;
    bus.note_valid = 1'b1; bus.note = 6'd4; bus.duration = 6'd4;
    tick();
    chk("F_in_wait", 32'(bus.wr_en), 32'd1);
    bus.note_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("F_rst_we",   32'(bus.wr_en),      32'd0);
    chk("F_rst_data", 32'(bus.wr_data),    32'd0);
    chk("F_rst_rec",  32'(bus.recording),  32'd0);
    chk("F_rst_rdy",  32'(bus.note_ready), 32'd0);
    bus.slot = 2'd3;
    bus.record = 1'b1;
    tick();
    chk("F_held_rec", 32'(bus.recording), 32'd0);
    reset = 1'b0;
    tick();
    chk("F_start_rec", 32'(bus.recording), 32'd1);

    // G: 127 notes at gap 0 with record held -> overflow and end at 127.
    for (int i = 0; i < 127; i++) begin
      nv = 6'(1 + (i % 60));
      bus.note_valid = 1'b1; bus.note = nv; bus.duration = 6'd2;
      tick();
      chk("G_word", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}),
          32'({1'b1, 2'd3, 7'(i), 1'b0, nv, 6'd2, 3'd0}));
      bus.note_valid = 1'b0;
      tick();
    end
    chk("G_end_we",   32'(bus.wr_en),    32'd1);
    chk("G_end_addr", 32'(bus.wr_addr),  32'h1FF);
    chk("G_end_data", 32'(bus.wr_data),  32'h0000);
    chk("G_end_ovf",  32'(bus.overflow), 32'd1);
    tick();
    chk("G_done_pulse", 32'(bus.rec_done), 32'd1);
    chk("G_ram126", 32'(ram[9'h1FE]), 32'h0E10);
    chk("G_ram127", 32'(ram[9'h1FF]), 32'h0000);
    tick();
    chk("G_hold_pulse", 32'(bus.rec_done),   32'd0);
    chk("G_hold_rdy",   32'(bus.note_ready), 32'd0);
    chk("G_hold_rec",   32'(bus.recording),  32'd0);
    bus.record = 1'b0;
    tick();
    chk("G_idle_ovf", 32'(bus.overflow), 32'd1);
    bus.record = 1'b1;
    tick();
    chk("G_restart_ovf", 32'(bus.overflow),   32'd0);
    chk("G_restart_rdy", 32'(bus.note_ready), 32'd1);
    bus.record = 1'b0;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
